dcache_req_arbiter: RTL

// - Shares the single data-cache request port between NUM_REQ LSU requesters (store unit, AMO path, load unit).
// - Picks one requester per handshake and holds that choice until the cache grants it.
// - Returns in-order responses to the requester that issued each one, using an outstanding-ID FIFO.
// - Sits between the LSU sub-units and the dcache request/response interface.

---
 rtl/dcache_arb_pkg.sv | 51 +++++
 rtl/dcache_arb_id_fifo.sv | 57 +++++
 rtl/dcache_req_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared types and helpers for the dcache request arbiter.
// Optional build macro: DCACHE_ARB_FIXED_PRIO_EN (see dcache_req_arbiter).
package dcache_arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int ADDR_W    = 34;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_OUTST = 4;
  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int CNT_W     = $clog2(MAX_OUTST + 1);

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              we;
  } req_t;

  // First valid index at or after ptr, searching cyclically.
  // The search runs from the farthest offset down, so the nearest wins.
  function automatic id_t rr_pick(
    input logic [NUM_REQ-1:0] valid,
    input id_t                ptr
  );
    id_t pick;
    pick = ptr;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (valid[k] && k == (int'(ptr) + off) % NUM_REQ)
          pick = id_t'(k);
      end
    end
    return pick;
  endfunction

  // Pointer step with wrap from NUM_REQ-1 back to 0.
  function automatic id_t next_ptr(input id_t id);
    if (int'(id) == NUM_REQ - 1)
      return '0;
    return id_t'(int'(id) + 1);
  endfunction

endpackage

// File: rtl/dcache_arb_id_fifo.sv
// Outstanding-ID FIFO for the dcache request arbiter.
// Synchronous, power-of-2 depth, push/pop in the same cycle allowed.
module dcache_arb_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;
  assign dout_o  = mem[rptr];

  // Pointers and occupancy; both ends may move in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= din_i;
  end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares the dcache request port between the LSU requesters.
// DCACHE_ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest).
module dcache_req_arbiter
  import dcache_arb_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  input  logic [NUM_REQ*BE_W-1:0]   req_be_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  output logic [NUM_REQ-1:0]        req_gnt_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      mem_req_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic [BE_W-1:0]           mem_be_o,
  output logic                      mem_we_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      idle_o,
  output logic                      err_o
);

  arb_state_e       state_q;
  arb_state_e       state_d;
  id_t              lock_q;
  id_t              ptr;
  id_t              win;
  id_t              sel;
  id_t              head;
  req_t             reqs [NUM_REQ];
  req_t             cur;
  logic             mem_req;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic             err_q;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  id_t ptr_q;
  assign ptr = ptr_q;

  // Round-robin pointer moves past each granted requester.
  always_ff @(posedge clk_i) begin
    if (rst_i)     ptr_q <= '0;
    else if (push) ptr_q <= next_ptr(sel);
  end
`endif

  // Unpack the requester payload slices.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      reqs[k].addr  = req_addr_i[k*ADDR_W +: ADDR_W];
      reqs[k].wdata = req_wdata_i[k*DATA_W +: DATA_W];
      reqs[k].be    = req_be_i[k*BE_W +: BE_W];
      reqs[k].we    = req_we_i[k];
    end
  end

  assign win = rr_pick(req_valid_i, ptr);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ARB;
    else       state_q <= state_d;
  end

  // Next-state: lock on an ungranted request, release on grant.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:  if (mem_req && !mem_gnt_i) state_d = LOCK;
      LOCK: if (mem_gnt_i)             state_d = ARB;
    endcase
  end

  // Remember the winner that has to stay on the port.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      lock_q <= '0;
    else if (state_q == ARB && state_d == LOCK)
      lock_q <= win;
  end

  // Outputs: selection, handshakes and one-hot strobes.
  always_comb begin
    sel     = win;
    mem_req = 1'b0;
    unique case (state_q)
      ARB: begin
        sel     = win;
        mem_req = (|req_valid_i) && !fifo_full;
      end
      LOCK: begin
        sel     = lock_q;
        mem_req = 1'b1;
      end
    endcase
    cur = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (id_t'(k) == sel) cur = reqs[k];
    end
    push        = mem_req && mem_gnt_i;
    pop         = mem_rvalid_i && !fifo_empty;
    req_gnt_o   = '0;
    rsp_valid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_gnt_o[k]   = push && (id_t'(k) == sel);
      rsp_valid_o[k] = pop && (id_t'(k) == head);
    end
  end

  assign mem_req_o   = mem_req;
  assign mem_addr_o  = mem_req ? cur.addr  : '0;
  assign mem_wdata_o = mem_req ? cur.wdata : '0;
  assign mem_be_o    = mem_req ? cur.be    : '0;
  assign mem_we_o    = mem_req && cur.we;
  assign rsp_rdata_o = pop ? mem_rdata_i : '0;
  assign idle_o      = (state_q == ARB) && (fifo_cnt == '0);
  assign err_o       = err_q;

  // Sticky flag for a response with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (mem_rvalid_i && fifo_empty)
      err_q <= 1'b1;
  end

  dcache_arb_id_fifo #(
    .W     (ID_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (sel),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule
